hazard_tracker: RTL and testbench

Per-stage hazard bookkeeping pipeline for the 5-stage MIPS core: it carries each instruction's destination register (A3), remaining result latency (Tnew) and source register numbers from D through E, M and W. It feeds `Tnew_E`, `Tnew_M`, `A3_E` and `A3_M` back to the stall unit, and consumes that unit's `E_REG_clr` to insert bubbles. It also generates the forwarding-mux selects for the D, E and M stage operand muxes, so one block owns all register-dependency state.

---
 rtl/hazard_tracker.sv | 130 +++++++++++++
 tb/tb_hazard_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Register-dependency bookkeeping for the 5-stage pipeline: carries Tnew/A3/sources through E, M
// and W and derives forwarding selects. Optional stall counter enabled by `define HAZARD_STAT_EN.
module hazard_tracker (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] Tnew_D,
   input  logic [4:0] A3_D,
   input  logic [4:0] A1_D,
   input  logic [4:0] A2_D,
   input  logic       E_REG_clr,
   output logic [2:0] Tnew_E,
   output logic [2:0] Tnew_M,
   output logic [4:0] A3_E,
   output logic [4:0] A3_M,
   output logic [4:0] A3_W,
   output logic [1:0] FwdRs_D,
   output logic [1:0] FwdRt_D,
   output logic [1:0] FwdRs_E,
   output logic [1:0] FwdRt_E,
   output logic [1:0] FwdRt_M
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic [2:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d, tnew_w_q, tnew_w_d;
   logic [4:0] a3_e_q, a3_e_d, a1_e_q, a1_e_d, a2_e_q, a2_e_d;
   logic [4:0] a3_m_q, a3_m_d, a2_m_q, a2_m_d;
   logic [4:0] a3_w_q, a3_w_d;

   function automatic logic [2:0] dec_sat(input logic [2:0] t);
      return (t == 3'd0) ? 3'd0 : t - 3'd1;
   endfunction

   // A producer forwards only once its result exists; register 0 is never a real dependency.
   function automatic logic hit(input logic [4:0] a3, input logic [2:0] tnew,
                                input logic [4:0] src);
      return (a3 == src) && (src != 5'd0) && (tnew == 3'd0);
   endfunction

   always_comb begin
      tnew_e_d = Tnew_D;
      a3_e_d   = A3_D;
      a1_e_d   = A1_D;
      a2_e_d   = A2_D;
      if (E_REG_clr) begin
         tnew_e_d = 3'd0;
         a3_e_d   = 5'd0;
         a1_e_d   = 5'd0;
         a2_e_d   = 5'd0;
      end
      tnew_m_d = dec_sat(tnew_e_q);
      a3_m_d   = a3_e_q;
      a2_m_d   = a2_e_q;
      tnew_w_d = dec_sat(tnew_m_q);
      a3_w_d   = a3_m_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tnew_e_q <= 3'd0;
         a3_e_q   <= 5'd0;
         a1_e_q   <= 5'd0;
         a2_e_q   <= 5'd0;
         tnew_m_q <= 3'd0;
         a3_m_q   <= 5'd0;
         a2_m_q   <= 5'd0;
         tnew_w_q <= 3'd0;
         a3_w_q   <= 5'd0;
      end else begin
         tnew_e_q <= tnew_e_d;
         a3_e_q   <= a3_e_d;
         a1_e_q   <= a1_e_d;
         a2_e_q   <= a2_e_d;
         tnew_m_q <= tnew_m_d;
         a3_m_q   <= a3_m_d;
         a2_m_q   <= a2_m_d;
         tnew_w_q <= tnew_w_d;
         a3_w_q   <= a3_w_d;
      end
   end

   assign Tnew_E = tnew_e_q;
   assign Tnew_M = tnew_m_q;
   assign A3_E   = a3_e_q;
   assign A3_M   = a3_m_q;
   assign A3_W   = a3_w_q;

   // Nearest producer wins; a matching but unready stage falls through to older ones.
   always_comb begin
      FwdRs_D = 2'd0;
      if      (hit(a3_e_q, tnew_e_q, A1_D)) FwdRs_D = 2'd1;
      else if (hit(a3_m_q, tnew_m_q, A1_D)) FwdRs_D = 2'd2;
      else if (hit(a3_w_q, tnew_w_q, A1_D)) FwdRs_D = 2'd3;

      FwdRt_D = 2'd0;
      if      (hit(a3_e_q, tnew_e_q, A2_D)) FwdRt_D = 2'd1;
      else if (hit(a3_m_q, tnew_m_q, A2_D)) FwdRt_D = 2'd2;
      else if (hit(a3_w_q, tnew_w_q, A2_D)) FwdRt_D = 2'd3;

      FwdRs_E = 2'd0;
      if      (hit(a3_m_q, tnew_m_q, a1_e_q)) FwdRs_E = 2'd2;
      else if (hit(a3_w_q, tnew_w_q, a1_e_q)) FwdRs_E = 2'd3;

      FwdRt_E = 2'd0;
      if      (hit(a3_m_q, tnew_m_q, a2_e_q)) FwdRt_E = 2'd2;
      else if (hit(a3_w_q, tnew_w_q, a2_e_q)) FwdRt_E = 2'd3;

      FwdRt_M = 2'd0;
      if (hit(a3_w_q, tnew_w_q, a2_m_q)) FwdRt_M = 2'd3;
   end

`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (E_REG_clr && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt_q <= 32'd0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios plus randomized traffic compared
// against a record-level pipeline model.
module tb_hazard_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] Tnew_D;
   logic [4:0] A3_D, A1_D, A2_D;
   logic       E_REG_clr;
   logic [2:0] Tnew_E, Tnew_M;
   logic [4:0] A3_E, A3_M, A3_W;
   logic [1:0] FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M;
`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   hazard_tracker dut (
      .clk(clk), .reset(reset), .Tnew_D(Tnew_D), .A3_D(A3_D), .A1_D(A1_D), .A2_D(A2_D),
      .E_REG_clr(E_REG_clr), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .A3_E(A3_E), .A3_M(A3_M),
      .A3_W(A3_W), .FwdRs_D(FwdRs_D), .FwdRt_D(FwdRt_D), .FwdRs_E(FwdRs_E),
      .FwdRt_E(FwdRt_E), .FwdRt_M(FwdRt_M)
`ifdef HAZARD_STAT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: one record per in-flight stage.
   typedef struct {
      int unsigned tnew;
      int unsigned a3;
      int unsigned a1;
      int unsigned a2;
   } rec_t;

   rec_t pe, pm, pw;
   rec_t zero_rec = '{0, 0, 0, 0};

   function automatic rec_t age(input rec_t r);
      rec_t n = r;
      n.tnew = (r.tnew > 0) ? r.tnew - 1 : 0;
      return n;
   endfunction

   function automatic rec_t stage(input int code);
      if (code == 1) return pe;
      if (code == 2) return pm;
      return pw;
   endfunction

   // Walk producers from 'first' (1=E, 2=M, 3=W) toward W; first ready match wins.
   function automatic int sel(input int unsigned src, input int first);
      for (int c = first; c <= 3; c++) begin
         rec_t p = stage(c);
         if (src != 0 && p.a3 == src && p.tnew == 0) return c;
      end
      return 0;
   endfunction

   function automatic logic [30:0] exp_vec();
      return {3'(pe.tnew), 3'(pm.tnew), 5'(pe.a3), 5'(pm.a3), 5'(pw.a3),
              2'(sel(A1_D, 1)), 2'(sel(A2_D, 1)), 2'(sel(pe.a1, 2)), 2'(sel(pe.a2, 2)),
              2'(sel(pm.a2, 3))};
   endfunction

   wire [30:0] obs_vec = {Tnew_E, Tnew_M, A3_E, A3_M, A3_W,
                          FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M};

   task automatic drive(input int t, input int a3, input int a1, input int a2, input bit clr);
      Tnew_D = 3'(t); A3_D = 5'(a3); A1_D = 5'(a1); A2_D = 5'(a2); E_REG_clr = clr;
   endtask

   task automatic model_reset();
      pe = zero_rec; pm = zero_rec; pw = zero_rec;
   endtask

   task automatic clock_edge();
      @(posedge clk);
      if (reset) model_reset();
      else begin
         pw = age(pm);
         pm = age(pe);
         pe = E_REG_clr ? zero_rec : '{int'(Tnew_D), int'(A3_D), int'(A1_D), int'(A2_D)};
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(2, 3, 3, 3, 1'b0);
      clock_edge();
      clock_edge();
      #2 reset = 1'b1;
      model_reset();
      #1;
      compared++;
      if (obs_vec !== 31'd0) begin
         mismatched++;
         $display("FAIL reset_async got=%h exp=0", obs_vec);
      end
      clock_edge();
      #2 reset = 1'b0;
      drive(0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         clock_edge();
         compared++;
         if (obs_vec !== 31'd0) begin
            mismatched++;
            $display("FAIL reset_zero_feed cyc=%0d got=%h exp=0", i, obs_vec);
         end
      end
   endtask

   task automatic test_alu_chain();
      drive(1, 8, 0, 0, 1'b0);
      clock_edge();
      drive(0, 0, 8, 0, 1'b0);
      #1;
      compared++;
      if ({Tnew_E, A3_E, FwdRs_D} !== {3'd1, 5'd8, 2'd0}) begin
         mismatched++;
         $display("FAIL alu_e got=%0d/%0d/%0d exp=1/8/0", Tnew_E, A3_E, FwdRs_D);
      end
      clock_edge();
      compared++;
      if ({Tnew_M, FwdRs_E} !== {3'd0, 2'd2}) begin
         mismatched++;
         $display("FAIL alu_fwd_e got=%0d/%0d exp=0/2", Tnew_M, FwdRs_E);
      end
   endtask

   task automatic test_lw();
      drive(2, 9, 0, 0, 1'b0);
      clock_edge();
      drive(0, 0, 0, 0, 1'b0);
      compared++;
      if (Tnew_E !== 3'd2) begin
         mismatched++;
         $display("FAIL lw_tnew_e got=%0d exp=2", Tnew_E);
      end
      clock_edge();
      compared++;
      if ({Tnew_M, A3_M} !== {3'd1, 5'd9}) begin
         mismatched++;
         $display("FAIL lw_tnew_m got=%0d/%0d exp=1/9", Tnew_M, A3_M);
      end
      clock_edge();
      drive(0, 0, 0, 9, 1'b0);
      #1;
      compared++;
      if ({A3_W, FwdRt_D} !== {5'd9, 2'd3}) begin
         mismatched++;
         $display("FAIL lw_fwd_w got=%0d/%0d exp=9/3", A3_W, FwdRt_D);
      end
   endtask

   task automatic test_bubble();
      drive(1, 7, 0, 0, 1'b0);
      clock_edge();
      drive(1, 5, 0, 0, 1'b1);
      clock_edge();
      compared++;
      if ({Tnew_E, A3_E, Tnew_M, A3_M} !== {3'd0, 5'd0, 3'd0, 5'd7}) begin
         mismatched++;
         $display("FAIL bubble got=%0d/%0d/%0d/%0d exp=0/0/0/7", Tnew_E, A3_E, Tnew_M, A3_M);
      end
   endtask

   task automatic test_priority();
      drive(0, 4, 0, 0, 1'b0);
      clock_edge();
      clock_edge();
      drive(0, 0, 4, 0, 1'b0);
      #1;
      compared++;
      if (FwdRs_D !== 2'd1) begin
         mismatched++;
         $display("FAIL prio_e_over_m got=%0d exp=1", FwdRs_D);
      end
      A1_D = 5'd0;
      #1;
      compared++;
      if (FwdRs_D !== 2'd0) begin
         mismatched++;
         $display("FAIL prio_r0 got=%0d exp=0", FwdRs_D);
      end
      // Unready E producer of the same register must fall through to M.
      drive(2, 4, 0, 0, 1'b0);
      clock_edge();
      A1_D = 5'd4;
      #1;
      compared++;
      if (FwdRs_D !== 2'd2) begin
         mismatched++;
         $display("FAIL prio_fallthrough got=%0d exp=2", FwdRs_D);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
         #1;
         compared++;
         if (obs_vec !== exp_vec()) begin
            mismatched++;
            $display("FAIL rand_comb i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
         end
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            compared++;
            if (obs_vec !== exp_vec()) begin
               mismatched++;
               $display("FAIL rand_reset i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
            end
         end
         clock_edge();
         reset = 1'b0;
         compared++;
         if (obs_vec !== exp_vec()) begin
            mismatched++;
            $display("FAIL rand_edge i=%0d got=%h exp=%h", i, obs_vec, exp_vec());
         end
      end
   endtask

`ifdef HAZARD_STAT_EN
   task automatic test_stat();
      #2 reset = 1'b1;
      clock_edge();
      #2 reset = 1'b0;
      model_reset();
      drive(1, 5, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) clock_edge();
      drive(0, 0, 0, 0, 1'b0);
      clock_edge();
      compared++;
      if (stall_cnt !== 32'd3) begin
         mismatched++;
         $display("FAIL stat_count got=%0d exp=3", stall_cnt);
      end
      #2 reset = 1'b1;
      #1;
      compared++;
      if (stall_cnt !== 32'd0) begin
         mismatched++;
         $display("FAIL stat_reset got=%0d exp=0", stall_cnt);
      end
      clock_edge();
      #2 reset = 1'b0;
      model_reset();
   endtask
`endif

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 1'b0);
      model_reset();
      #12;
      test_reset();
      test_alu_chain();
      test_lw();
      test_bubble();
      test_priority();
      test_random();
`ifdef HAZARD_STAT_EN
      test_stat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
